// File: rtl/pattern_det_ctrl_if.sv
// Interface for pattern_det_ctrl: config handshake, run control, serial input and status.
// The master drives the config, run control and data; the slave is the detector.
interface pattern_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [WIN_W-1:0]   cfg_window;
  logic               cfg_overlap;
  logic               start;
  logic               abort;
  logic               x;
  logic               x_valid;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_window, cfg_overlap,
    output start, abort, x, x_valid,
    input  cfg_ready, y, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_window, cfg_overlap,
    input  start, abort, x, x_valid,
    output cfg_ready, y, match_count, busy, done
  );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Runtime-programmable serial pattern detector with windowed runs and match counting.
// Optional build macro PDC_STOP_ON_MATCH_EN: the first match ends the run with done.
module pattern_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pattern_det_ctrl_if.slave  bus
);
  localparam int                 LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]   CNT_SAT = '1;
`ifdef PDC_STOP_ON_MATCH_EN
  localparam bit STOP_ON_MATCH = 1'b1;
`else
  localparam bit STOP_ON_MATCH = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t             state_r, state_nx_s;
  logic [MAX_LEN-1:0] pat_r, hist_sh_s, mask_s;
  // Only the older MAX_LEN-1 bits are stored; the current bit is appended on the fly.
  logic [MAX_LEN-2:0] hist_r, hist_nx_s;
  logic [LEN_W-1:0]   len_r, fill_r, fill_nx_s, fill_inc_s, cfg_len_s;
  logic [WIN_W-1:0]   win_r, beats_r, beats_nx_s;
  logic               ovl_r;
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
  logic               y_r, y_nx_s, done_r, done_nx_s;
  logic               cfg_take_s, beat_s, match_s, win_end_s;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (LEN_W'(i) < len);
    return m;
  endfunction

  // Clamp the offered length into 1..MAX_LEN
  always_comb begin
    if (bus.cfg_len == '0) begin
      cfg_len_s = LEN_W'(1);
    end else if (bus.cfg_len > LEN_MAX) begin
      cfg_len_s = LEN_MAX;
    end else begin
      cfg_len_s = bus.cfg_len;
    end
  end

  // Next-state, datapath update and output strobes
  always_comb begin
    state_nx_s = state_r;
    hist_nx_s  = hist_r;
    fill_nx_s  = fill_r;
    beats_nx_s = beats_r;
    cnt_nx_s   = cnt_r;
    y_nx_s     = 1'b0;
    done_nx_s  = 1'b0;
    cfg_take_s = bus.cfg_valid && (state_r == IDLE);
    hist_sh_s  = {hist_r, bus.x};
    fill_inc_s = (fill_r == LEN_MAX) ? fill_r : fill_r + LEN_W'(1);
    mask_s     = len_mask(len_r);
    beat_s     = (state_r == ARMED) && bus.x_valid && !bus.abort;
    match_s    = beat_s && ((hist_sh_s & mask_s) == (pat_r & mask_s)) && (fill_inc_s >= len_r);
    win_end_s  = beat_s && (win_r != '0) &&
                 (({1'b0, beats_r} + (WIN_W+1)'(1)) == {1'b0, win_r});
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx_s = ARMED;
          hist_nx_s  = '0;
          fill_nx_s  = '0;
          beats_nx_s = '0;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ARMED: begin
        if (bus.abort) begin
          state_nx_s = IDLE;
        end else if (beat_s) begin
          hist_nx_s  = hist_sh_s[MAX_LEN-2:0];
          beats_nx_s = beats_r + WIN_W'(1);
          // Non-overlapping mode starts a fresh fill so the matched bits cannot be reused
          fill_nx_s  = (match_s && !ovl_r) ? '0 : fill_inc_s;
          if (match_s && (cnt_r != CNT_SAT)) begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_nx_s = cnt_r;
          end
          y_nx_s = match_s;
          if (win_end_s || (STOP_ON_MATCH && match_s)) begin
            state_nx_s = IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = ARMED;
          end
        end else begin
          state_nx_s = ARMED;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Run datapath and registered output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r  <= '0;
      fill_r  <= '0;
      beats_r <= '0;
      cnt_r   <= '0;
      y_r     <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      hist_r  <= hist_nx_s;
      fill_r  <= fill_nx_s;
      beats_r <= beats_nx_s;
      cnt_r   <= cnt_nx_s;
      y_r     <= y_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Configuration capture, only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r <= '0;
      len_r <= LEN_W'(1);
      win_r <= '0;
      ovl_r <= 1'b1;
    end else if (cfg_take_s) begin
      pat_r <= bus.cfg_pattern;
      len_r <= cfg_len_s;
      win_r <= bus.cfg_window;
      ovl_r <= bus.cfg_overlap;
    end
  end

  assign bus.cfg_ready   = (state_r == IDLE);
  assign bus.busy        = (state_r == ARMED);
  assign bus.y           = y_r;
  assign bus.done        = done_r;
  assign bus.match_count = cnt_r;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Scoreboard bench for pattern_det_ctrl (default build, CNT_W=3 so saturation is reachable).
module tb_pattern_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 3;
  localparam int WIN_W   = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pattern_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus();
  pattern_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic             y;
    logic             done;
    logic             busy;
    logic             rdy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_bad = 0, y_seen = 0, done_seen = 0;

  logic [MAX_LEN-1:0] c_pat;
  logic [LEN_W-1:0]   c_len;
  logic [WIN_W-1:0]   c_win;
  logic               c_ovl;

  bit m_armed, m_ovl;
  int m_pat, m_len, m_win, m_hist, m_bits, m_beats, m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_pat = 0; m_len = 1; m_win = 0; m_ovl = 1'b1;
    m_hist = 0; m_bits = 0; m_beats = 0; m_cnt = 0;
  endtask

  // One clock: drive inputs, predict, push expectation, then pop and compare after the edge
  task automatic cycle(input bit cv, input bit st, input bit ab, input bit xb, input bit xv);
    exp_t e;
    int   mask;
    bus.cfg_valid = cv; bus.cfg_pattern = c_pat; bus.cfg_len = c_len;
    bus.cfg_window = c_win; bus.cfg_overlap = c_ovl;
    bus.start = st; bus.abort = ab; bus.x = xb; bus.x_valid = xv;
    e = '0;
    if (!m_armed) begin
      if (cv) begin
        m_pat = int'(c_pat);
        m_len = (c_len == 0) ? 1 : ((int'(c_len) > MAX_LEN) ? MAX_LEN : int'(c_len));
        m_win = int'(c_win);
        m_ovl = c_ovl;
      end
      if (st) begin
        m_armed = 1'b1; m_hist = 0; m_bits = 0; m_beats = 0; m_cnt = 0;
      end
    end else if (ab) begin
      m_armed = 1'b0;
    end else if (xv) begin
      m_hist = (m_hist << 1) | int'(xb);
      m_bits++;
      m_beats++;
      mask = (1 << m_len) - 1;
      if (m_bits >= m_len && ((m_hist & mask) == (m_pat & mask))) begin
        e.y = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) m_bits = 0;
      end
      if (m_win != 0 && m_beats == m_win) begin
        m_armed = 1'b0;
        e.done = 1'b1;
      end
    end
    e.busy = m_armed;
    e.rdy  = !m_armed;
    e.cnt  = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("y",           32'(bus.y),           32'(e.y));
    check_val("done",        32'(bus.done),        32'(e.done));
    check_val("busy",        32'(bus.busy),        32'(e.busy));
    check_val("cfg_ready",   32'(bus.cfg_ready),   32'(e.rdy));
    check_val("match_count", 32'(bus.match_count), 32'(e.cnt));
    y_seen    += int'(bus.y);
    done_seen += int'(bus.done);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, 1'b0, bits[i], 1'b1);
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic [WIN_W-1:0] w, input logic o);
    c_pat = p; c_len = l; c_win = w; c_ovl = o;
    y_seen = 0; done_seen = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_window = '0;
    bus.cfg_overlap = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.x = 1'b0; bus.x_valid = 1'b0;
    set_cfg('0, '0, '0, 1'b0);
    model_reset();
    rst_n = 1'b0;
    #23;
    check_val("rst_y",         32'(bus.y),           32'd0);
    check_val("rst_done",      32'(bus.done),        32'd0);
    check_val("rst_busy",      32'(bus.busy),        32'd0);
    check_val("rst_cfg_ready", 32'(bus.cfg_ready),   32'd1);
    check_val("rst_count",     32'(bus.match_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1101, overlapping, window 7, with an x_valid-low gap mid-stream
    set_cfg(8'b0000_1101, 4'd4, 16'd7, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b110, 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b1101, 4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("ovl_y_pulses", 32'(y_seen), 32'd2);
    check_val("ovl_done",     32'(done_seen), 32'd1);
    check_val("ovl_count",    32'(bus.match_count), 32'd2);

    // Same stream, non-overlapping
    set_cfg(8'b0000_1101, 4'd4, 16'd7, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b1101101, 7);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("novl_y_pulses", 32'(y_seen), 32'd1);
    check_val("novl_done",     32'(done_seen), 32'd1);
    check_val("novl_count",    32'(bus.match_count), 32'd1);

    // Unlimited window, 11: eight 1s (a start mid-run), then abort on a beat
    set_cfg(8'b0000_0011, 4'd2, 16'd0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b1111, 4);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    feed(16'b111, 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_val("unl_y_pulses", 32'(y_seen), 32'd7);
    check_val("unl_done",     32'(done_seen), 32'd0);
    check_val("unl_count",    32'(bus.match_count), 32'd7);
    check_val("unl_ready",    32'(bus.cfg_ready), 32'd1);

    // Config offered while armed must wait; then len=0 acts as len=1
    set_cfg(8'b0000_1101, 4'd4, 16'd3, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8'b0000_0001, 4'd0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("held_y_pulses", 32'(y_seen), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b101, 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("len0_y_pulses", 32'(y_seen), 32'd2);
    check_val("len0_done",     32'(done_seen), 32'd1);

    // Counter saturation: ten 1s, window 10
    set_cfg(8'b0000_0001, 4'd1, 16'd10, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'h03FF, 10);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("sat_y_pulses", 32'(y_seen), 32'd10);
    check_val("sat_count",    32'(bus.match_count), 32'd7);

    // Oversized length clamps to MAX_LEN
    set_cfg(8'hFF, 4'd15, 16'd0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'h01FF, 9);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("clamp_y_pulses", 32'(y_seen), 32'd2);

    // Asynchronous reset mid-run while y is high
    set_cfg(8'b0000_0001, 4'd1, 16'd0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b11, 2);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_y",     32'(bus.y),           32'd0);
    check_val("mid_rst_busy",  32'(bus.busy),        32'd0);
    check_val("mid_rst_count", 32'(bus.match_count), 32'd0);
    check_val("mid_rst_ready", 32'(bus.cfg_ready),   32'd1);
    check_val("mid_rst_done",  32'(bus.done),        32'd0);
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Default config after reset: pattern 0, len 1
    set_cfg('0, '0, '0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b01, 2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("dflt_y_pulses", 32'(y_seen), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
